ili_bus_writer: RTL and testbench

Avalon-MM slave that replaces the per-signal bit-banged PIOs for the 2.4" ILI9325-class TFT with a hardware 8080-style write engine. The Nios writes command or data words into a small FIFO; an FSM drives CS_n/RS/WR_n/DB with programmable strobe timing. Sits between the Avalon fabric and the TFT pins, directly in place of the WR_n PIO stage.

---
 rtl/ili_bus_writer_pkg.sv | 53 +++++
 rtl/ili_bus_writer_if.sv | 25 ++
 rtl/ili_bus_writer_cmd_fifo.sv | 73 +++++++
 rtl/ili_bus_writer.sv | 249 ++++++++++++++++++++++++
 tb/tb_ili_bus_writer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ili_bus_writer_pkg.sv
// ----------------------------------------------------------------------------
// ili_bus_pkg
// Shared definitions for the ILI9325-class 8080 write engine:
//   - state_e       : write-engine FSM states
//   - ADDR_*        : Avalon register map word addresses
//   - STAT_*        : bit positions inside the status word (address 2)
//   - fifo_entry_t  : one queued bus write {rs, data[, count]}
//   - clamp_cyc()   : maps a strobe width of 0 to 1
// Build option: ILI_BUS_WRITER_REPEAT_EN adds a 16-bit repeat count to
// each FIFO entry for rectangle fills.
// ----------------------------------------------------------------------------
package ili_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WR_LO = 2'd2,
    ST_WR_HI = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_FILL = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_LO_LSB  = 4;
  localparam int STAT_HI_LSB  = 8;
  localparam int STAT_LVL_LSB = 16;

`ifdef ILI_BUS_WRITER_REPEAT_EN
  typedef struct packed {
    logic        rs;
    logic [15:0] data;
    logic [15:0] count;
  } fifo_entry_t;
`else
  typedef struct packed {
    logic        rs;
    logic [15:0] data;
  } fifo_entry_t;
`endif

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // A zero-cycle strobe phase is meaningless on the panel; run it as one cycle.
  function automatic logic [3:0] clamp_cyc(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

endpackage

// File: rtl/ili_bus_writer_if.sv
// ----------------------------------------------------------------------------
// ili_bus_writer_if
// Avalon-MM slave bundle for ili_bus_writer.
//   address[1:0], chipselect, write_n, writedata[31:0] : master -> slave
//   readdata[31:0], waitrequest                        : slave -> master
// Modports: slave (the writer), master (the fabric / bench).
// ----------------------------------------------------------------------------
interface ili_bus_writer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, waitrequest
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/ili_bus_writer_cmd_fifo.sv
// ----------------------------------------------------------------------------
// ili_cmd_fifo
// Single-clock FIFO holding queued panel writes. Head entry is visible
// combinationally (show-ahead). Pushes while full and pops while empty are
// ignored. Full/empty reflect the level before any same-cycle pop.
// Ports:
//   clk, reset_n        : clock, async active-low reset (flushes the FIFO)
//   push_i, push_data_i : enqueue request and entry
//   pop_i               : dequeue request
//   head_o              : entry at the read pointer
//   level_o             : occupancy, 0..DEPTH
//   full_o, empty_o     : occupancy flags
// ----------------------------------------------------------------------------
module ili_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Pointer and occupancy tracking; reset empties the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ili_bus_writer.sv
// ----------------------------------------------------------------------------
// ili_bus_writer
// Avalon-MM slave driving an ILI9325-class TFT over an 8080 write-only bus.
// Writes to address 0/1 queue a command/data word; an FSM replays queued
// words as CS_n/RS/WR_n/DB cycles with programmable WR_n low/high widths.
// Ports:
//   clk, reset_n         : system clock, async active-low reset
//   avs (slave modport)  : address, chipselect, write_n, writedata,
//                          readdata (combinational), waitrequest
//   lcd_cs_n, lcd_rs     : panel select, command(0)/data(1)
//   lcd_wr_n, lcd_rd_n   : write strobe (panel latches on rise), read tied 1
//   lcd_db[15:0]         : parallel data
// Build option: ILI_BUS_WRITER_REPEAT_EN enables address 3 repeat-fill.
// Panel pins are registered, so they trail the FSM state by one clock.
// ----------------------------------------------------------------------------
module ili_bus_writer
  import ili_bus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LO_DEF     = 2,
  parameter int HI_DEF     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  ili_bus_writer_if.slave   avs,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [15:0]       lcd_db
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             wr_req_s;
  logic             fifo_addr_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [LVL_W-1:0] level_s;
  fifo_entry_t      push_entry_s;
  fifo_entry_t      head_s;
  logic             busy_s;
  logic [31:0]      status_s;
  logic             repeat_pending_s;

  logic [3:0]       lo_cyc_q;
  logic [3:0]       hi_cyc_q;
  state_e           state_q, state_d;
  fifo_entry_t      cur_q, cur_d;
  logic [3:0]       tmr_q, tmr_d;
  logic [3:0]       hi_lat_q, hi_lat_d;

`ifdef ILI_BUS_WRITER_REPEAT_EN
  logic [15:0]      rep_q, rep_d;

  // A zero-count fill is swallowed, so it never needs FIFO space.
  assign fifo_addr_s = (avs.address == ADDR_CMD) | (avs.address == ADDR_DATA) |
                       ((avs.address == ADDR_FILL) & (avs.writedata[31:16] != 16'd0));
  assign repeat_pending_s = (rep_q != 16'd0);
`else
  logic             unused_s;

  assign fifo_addr_s      = (avs.address == ADDR_CMD) | (avs.address == ADDR_DATA);
  assign repeat_pending_s = 1'b0;
  assign unused_s         = ^avs.writedata[31:16];
`endif

  // Full is checked before any same-cycle pop, so a full FIFO always stalls.
  assign wr_req_s        = avs.chipselect & ~avs.write_n;
  assign avs.waitrequest = wr_req_s & fifo_addr_s & fifo_full_s;
  assign accept_s        = wr_req_s & ~avs.waitrequest;
  assign push_s          = accept_s & fifo_addr_s;

  // Assemble the entry for the addressed write.
  always_comb begin
    push_entry_s      = '0;
    push_entry_s.rs   = (avs.address != ADDR_CMD);
    push_entry_s.data = avs.writedata[15:0];
`ifdef ILI_BUS_WRITER_REPEAT_EN
    if (avs.address == ADDR_FILL) begin
      push_entry_s.count = avs.writedata[31:16];
    end else begin
      push_entry_s.count = 16'd1;
    end
`endif
  end

  ili_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .level_o     (level_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Strobe timing register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_cyc_q <= 4'(LO_DEF);
      hi_cyc_q <= 4'(HI_DEF);
    end else if (accept_s && (avs.address == ADDR_CTRL)) begin
      lo_cyc_q <= clamp_cyc(avs.writedata[3:0]);
      hi_cyc_q <= clamp_cyc(avs.writedata[7:4]);
    end
  end

  // Status word readback.
  always_comb begin
    status_s                          = 32'd0;
    status_s[STAT_BUSY]               = busy_s;
    status_s[STAT_FULL]               = fifo_full_s;
    status_s[STAT_EMPTY]              = fifo_empty_s;
    status_s[STAT_LO_LSB +: 4]        = lo_cyc_q;
    status_s[STAT_HI_LSB +: 4]        = hi_cyc_q;
    status_s[STAT_LVL_LSB +: 8]       = 8'(level_s);
  end

  assign busy_s       = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign avs.readdata = (avs.address == ADDR_CTRL) ? status_s : 32'd0;
  assign lcd_rd_n     = 1'b1;

  // Write-engine next state. tmr counts the remaining cycles of the current
  // strobe phase; hi width is captured at SETUP so mid-word register writes
  // only affect the next word.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tmr_d    = tmr_q;
    hi_lat_d = hi_lat_q;
    pop_s    = 1'b0;
`ifdef ILI_BUS_WRITER_REPEAT_EN
    rep_d    = rep_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cur_d   = head_s;
`ifdef ILI_BUS_WRITER_REPEAT_EN
          rep_d   = head_s.count - 16'd1;
`endif
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        tmr_d    = lo_cyc_q - 4'd1;
        hi_lat_d = hi_cyc_q;
        state_d  = ST_WR_LO;
      end
      ST_WR_LO: begin
        if (tmr_q == 4'd0) begin
          tmr_d   = hi_lat_q - 4'd1;
          state_d = ST_WR_HI;
        end else begin
          tmr_d   = tmr_q - 4'd1;
        end
      end
      ST_WR_HI: begin
        if (tmr_q != 4'd0) begin
          tmr_d   = tmr_q - 4'd1;
        end else if (repeat_pending_s) begin
`ifdef ILI_BUS_WRITER_REPEAT_EN
          rep_d   = rep_q - 16'd1;
`endif
          state_d = ST_SETUP;
        end else if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          cur_d   = head_s;
`ifdef ILI_BUS_WRITER_REPEAT_EN
          rep_d   = head_s.count - 16'd1;
`endif
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write-engine state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      tmr_q    <= 4'd0;
      hi_lat_q <= 4'd0;
`ifdef ILI_BUS_WRITER_REPEAT_EN
      rep_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      tmr_q    <= tmr_d;
      hi_lat_q <= hi_lat_d;
`ifdef ILI_BUS_WRITER_REPEAT_EN
      rep_q    <= rep_d;
`endif
    end
  end

  // Panel pin registers; rs/db keep their last value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_rs   <= 1'b1;
      lcd_db   <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lcd_cs_n <= 1'b1;
          lcd_wr_n <= 1'b1;
        end
        ST_SETUP, ST_WR_HI: begin
          lcd_cs_n <= 1'b0;
          lcd_wr_n <= 1'b1;
          lcd_rs   <= cur_q.rs;
          lcd_db   <= cur_q.data;
        end
        ST_WR_LO: begin
          lcd_cs_n <= 1'b0;
          lcd_wr_n <= 1'b0;
          lcd_rs   <= cur_q.rs;
          lcd_db   <= cur_q.data;
        end
        default: begin
          lcd_cs_n <= 1'b1;
          lcd_wr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ili_bus_writer.sv
// ----------------------------------------------------------------------------
// tb_ili_bus_writer
// Directed bench for ili_bus_writer. A negedge monitor logs every completed
// WR_n strobe (fall cycle, low width, rs, db) and every CS_n release; the
// scenario tasks compare those logs with hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ili_bus_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
  logic [15:0] lcd_db;

  int checks = 0;
  int failures = 0;

  ili_bus_writer_if bus ();

  ili_bus_writer #(
    .FIFO_DEPTH (8),
    .LO_DEF     (2),
    .HI_DEF     (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus),
    .lcd_cs_n (lcd_cs_n),
    .lcd_rs   (lcd_rs),
    .lcd_wr_n (lcd_wr_n),
    .lcd_rd_n (lcd_rd_n),
    .lcd_db   (lcd_db)
  );

  always #5 clk = ~clk;

  // Strobe monitor
  int          cyc = 0;
  int          low_start = 0;
  int          cs_rises = 0;
  logic        prev_wr = 1'b1;
  logic        prev_cs = 1'b1;
  int          fall_q[$];
  int          low_q[$];
  logic        rs_q[$];
  logic [15:0] db_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && prev_wr && !lcd_wr_n) begin
      fall_q.push_back(cyc);
      low_start <= cyc;
    end
    if (reset_n && !prev_wr && lcd_wr_n) begin
      low_q.push_back(cyc - low_start);
      rs_q.push_back(lcd_rs);
      db_q.push_back(lcd_db);
    end
    if (reset_n && !prev_cs && lcd_cs_n) begin
      cs_rises <= cs_rises + 1;
    end
    prev_wr <= lcd_wr_n;
    prev_cs <= lcd_cs_n;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic avs_write(input logic [1:0] addr, input logic [31:0] data,
                           output int acc_cyc, output int stalls);
    int n;
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    #1;
    n = 0;
    while (bus.waitrequest === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%0d waitrequest stuck", addr);
    end
    stalls = n;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    bus.address = 2'd2;
    #1;
    while (bus.readdata[0] !== 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s_idle_timeout busy never cleared", tag);
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (lcd_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", lcd_cs_n); end
    checks++; if (lcd_wr_n !== 1'b1) begin failures++; $display("FAIL reset_wr_n got=%b exp=1", lcd_wr_n); end
    checks++; if (lcd_rs !== 1'b1) begin failures++; $display("FAIL reset_rs got=%b exp=1", lcd_rs); end
    checks++; if (lcd_rd_n !== 1'b1) begin failures++; $display("FAIL reset_rd_n got=%b exp=1", lcd_rd_n); end
    checks++; if (lcd_db !== 16'h0000) begin failures++; $display("FAIL reset_db got=%h exp=0000", lcd_db); end
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL reset_waitrequest got=%b exp=0", bus.waitrequest); end
    checks++; if (bus.readdata !== 32'd0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", bus.readdata); end
    reset_n = 1'b1;
    @(negedge clk);
    bus.address = 2'd2;
    #1;
    checks++; if (bus.readdata !== 32'h0000_0224) begin failures++; $display("FAIL reset_status got=%h exp=00000224", bus.readdata); end
  endtask

  task automatic test_cmd_write();
    int f0, r0, acc, st;
    f0 = fall_q.size();
    r0 = cs_rises;
    avs_write(2'd0, 32'h0000_0022, acc, st);
    wait_idle("cmd");
    checks++; if (fall_q.size() - f0 != 1) begin failures++; $display("FAIL cmd_strobes got=%0d exp=1", fall_q.size() - f0); end
    if (fall_q.size() > f0 && low_q.size() > f0) begin
      checks++; if (rs_q[f0] !== 1'b0) begin failures++; $display("FAIL cmd_rs got=%b exp=0", rs_q[f0]); end
      checks++; if (db_q[f0] !== 16'h0022) begin failures++; $display("FAIL cmd_db got=%h exp=0022", db_q[f0]); end
      checks++; if (low_q[f0] != 2) begin failures++; $display("FAIL cmd_low_width got=%0d exp=2", low_q[f0]); end
      checks++; if (fall_q[f0] - acc != 3) begin failures++; $display("FAIL cmd_latency got=%0d exp=3", fall_q[f0] - acc); end
    end
    checks++; if (lcd_cs_n !== 1'b1) begin failures++; $display("FAIL cmd_cs_release got=%b exp=1", lcd_cs_n); end
    checks++; if (cs_rises - r0 != 1) begin failures++; $display("FAIL cmd_cs_rises got=%0d exp=1", cs_rises - r0); end
  endtask

  task automatic test_timing();
    int f0, acc, st;
    avs_write(2'd2, 32'h0000_0031, acc, st);
    bus.address = 2'd2;
    #1;
    checks++; if (bus.readdata[11:4] !== 8'h31) begin failures++; $display("FAIL timing_readback got=%h exp=31", bus.readdata[11:4]); end
    f0 = fall_q.size();
    avs_write(2'd1, 32'h0000_F800, acc, st);
    avs_write(2'd1, 32'h0000_001F, st, st);
    wait_idle("timing");
    checks++; if (fall_q.size() - f0 != 2) begin failures++; $display("FAIL timing_strobes got=%0d exp=2", fall_q.size() - f0); end
    if (fall_q.size() >= f0 + 2 && low_q.size() >= f0 + 2) begin
      checks++; if (low_q[f0] != 1) begin failures++; $display("FAIL timing_low0 got=%0d exp=1", low_q[f0]); end
      checks++; if (low_q[f0+1] != 1) begin failures++; $display("FAIL timing_low1 got=%0d exp=1", low_q[f0+1]); end
      checks++; if (fall_q[f0+1] - fall_q[f0] != 5) begin failures++; $display("FAIL timing_period got=%0d exp=5", fall_q[f0+1] - fall_q[f0]); end
      checks++; if (fall_q[f0] - acc != 3) begin failures++; $display("FAIL timing_latency got=%0d exp=3", fall_q[f0] - acc); end
      checks++; if (db_q[f0] !== 16'hF800 || db_q[f0+1] !== 16'h001F) begin failures++; $display("FAIL timing_db got=%h,%h exp=F800,001F", db_q[f0], db_q[f0+1]); end
      checks++; if (rs_q[f0] !== 1'b1 || rs_q[f0+1] !== 1'b1) begin failures++; $display("FAIL timing_rs got=%b,%b exp=1,1", rs_q[f0], rs_q[f0+1]); end
    end
  endtask

  task automatic test_back_to_back();
    int f0, r0, acc0, acc, st, early_stalls, last_stalls;
    avs_write(2'd2, 32'h0000_0044, acc, st);
    f0 = fall_q.size();
    r0 = cs_rises;
    early_stalls = 0;
    last_stalls  = 0;
    acc0 = 0;
    for (int i = 0; i < 10; i++) begin
      avs_write(2'd1, 32'h0000_0100 + 32'(i), acc, st);
      if (i == 0) acc0 = acc;
      if (i < 9) early_stalls += st;
      else last_stalls = st;
    end
    checks++; if (early_stalls != 0) begin failures++; $display("FAIL b2b_early_stalls got=%0d exp=0", early_stalls); end
    checks++; if (last_stalls != 2) begin failures++; $display("FAIL b2b_full_stalls got=%0d exp=2", last_stalls); end
    wait_idle("b2b");
    checks++; if (fall_q.size() - f0 != 10) begin failures++; $display("FAIL b2b_strobes got=%0d exp=10", fall_q.size() - f0); end
    if (fall_q.size() >= f0 + 10 && low_q.size() >= f0 + 10) begin
      checks++; if (fall_q[f0] - acc0 != 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", fall_q[f0] - acc0); end
      for (int i = 0; i < 10; i++) begin
        checks++; if (db_q[f0+i] !== 16'h0100 + 16'(i) || rs_q[f0+i] !== 1'b1 || low_q[f0+i] != 4) begin
          failures++; $display("FAIL b2b_word%0d got db=%h rs=%b low=%0d exp db=%h rs=1 low=4", i, db_q[f0+i], rs_q[f0+i], low_q[f0+i], 16'h0100 + 16'(i));
        end
        if (i > 0) begin
          checks++; if (fall_q[f0+i] - fall_q[f0+i-1] != 9) begin failures++; $display("FAIL b2b_period%0d got=%0d exp=9", i, fall_q[f0+i] - fall_q[f0+i-1]); end
        end
      end
    end
    checks++; if (cs_rises - r0 != 1) begin failures++; $display("FAIL b2b_cs_gap got=%0d rises exp=1", cs_rises - r0); end
  endtask

  task automatic test_status();
    int acc, st;
    for (int i = 0; i < 4; i++) begin
      avs_write(2'd1, 32'h0000_0A00 + 32'(i), acc, st);
    end
    bus.address = 2'd2;
    #1;
    checks++; if (bus.readdata !== 32'h0003_0441) begin failures++; $display("FAIL status_busy got=%h exp=00030441", bus.readdata); end
    wait_idle("status");
    checks++; if (bus.readdata !== 32'h0000_0444) begin failures++; $display("FAIL status_drained got=%h exp=00000444", bus.readdata); end
  endtask

  task automatic test_reset_mid();
    int f0, l0, n, acc, st;
    f0 = fall_q.size();
    l0 = low_q.size();
    for (int i = 0; i < 4; i++) begin
      avs_write(2'd1, 32'h0000_5500 + 32'(i), acc, st);
    end
    n = 0;
    while (fall_q.size() - f0 < 2 && n < 500) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++; if (n >= 500 || lcd_wr_n !== 1'b0) begin failures++; $display("FAIL rstmid_reach_wr_lo got wr_n=%b falls=%0d exp wr_n=0 falls=2", lcd_wr_n, fall_q.size() - f0); end
    reset_n = 1'b0;
    #1;
    checks++; if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || lcd_rs !== 1'b1 || lcd_db !== 16'h0000) begin
      failures++; $display("FAIL rstmid_outputs got cs=%b wr=%b rs=%b db=%h exp 1 1 1 0000", lcd_cs_n, lcd_wr_n, lcd_rs, lcd_db);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    checks++; if (fall_q.size() - f0 != 2) begin failures++; $display("FAIL rstmid_no_more_strobes got=%0d exp=2", fall_q.size() - f0); end
    checks++; if (low_q.size() - l0 != 1) begin failures++; $display("FAIL rstmid_completed got=%0d exp=1", low_q.size() - l0); end
    bus.address = 2'd2;
    #1;
    checks++; if (bus.readdata !== 32'h0000_0224) begin failures++; $display("FAIL rstmid_status got=%h exp=00000224", bus.readdata); end
  endtask

  task automatic test_fill();
    int f0, acc, st;
    f0 = fall_q.size();
    avs_write(2'd3, 32'h0005_07E0, acc, st);
`ifdef ILI_BUS_WRITER_REPEAT_EN
    checks++; if (st != 0) begin failures++; $display("FAIL fill_stall got=%0d exp=0", st); end
    wait_idle("fill");
    checks++; if (fall_q.size() - f0 != 5) begin failures++; $display("FAIL fill_strobes got=%0d exp=5", fall_q.size() - f0); end
    if (fall_q.size() >= f0 + 5 && low_q.size() >= f0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (db_q[f0+i] !== 16'h07E0 || rs_q[f0+i] !== 1'b1 || low_q[f0+i] != 2) begin
          failures++; $display("FAIL fill_word%0d got db=%h rs=%b low=%0d exp db=07E0 rs=1 low=2", i, db_q[f0+i], rs_q[f0+i], low_q[f0+i]);
        end
        if (i > 0) begin
          checks++; if (fall_q[f0+i] - fall_q[f0+i-1] != 5) begin failures++; $display("FAIL fill_period%0d got=%0d exp=5", i, fall_q[f0+i] - fall_q[f0+i-1]); end
        end
      end
    end
    f0 = fall_q.size();
    avs_write(2'd3, 32'h0000_1234, acc, st);
    checks++; if (st != 0) begin failures++; $display("FAIL fill_zero_stall got=%0d exp=0", st); end
`else
    checks++; if (st != 0) begin failures++; $display("FAIL fill_off_stall got=%0d exp=0", st); end
`endif
    repeat (30) @(negedge clk);
    #1;
    checks++; if (fall_q.size() - f0 != 0) begin failures++; $display("FAIL fill_no_strobe got=%0d exp=0", fall_q.size() - f0); end
    bus.address = 2'd2;
    #1;
    checks++; if (bus.readdata !== 32'h0000_0224) begin failures++; $display("FAIL fill_status got=%h exp=00000224", bus.readdata); end
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_timing();
    test_back_to_back();
    test_status();
    test_reset_mid();
    test_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
